// File: rtl/fwd_ctrl.sv
// fwd_ctrl -- forwarding and load-use hazard controller.
//
// Tracks the destination register of the instructions in EX, MEM and WB and
// produces registered select codes for the EX-stage operand muxes, plus a
// combinational stall when a load is followed by a dependent instruction.
//
// Ports
//   clk, rst      pipeline clock; synchronous active-high reset
//   id_valid      ID stage holds a real instruction
//   id_rs1/rs2    source registers of the ID instruction
//   id_use_rs1/2  ID instruction actually reads rs1 / rs2
//   id_rd, id_wr  destination register and its write enable
//   id_load       ID instruction is a load (result only ready at WB)
//   flush         kill the ID instruction; a bubble enters EX
//   stall         combinational; hold PC and IF/ID, bubble into EX
//   fwd_a/fwd_b   registered operand selects: 00 regfile, 01 MEM, 10 WB
//   ex_valid      registered; EX holds a real instruction
//
// Handshake: there is no valid/ready pair here. An ID instruction is accepted
// into EX on a rising edge exactly when id_valid && !flush && !stall; in every
// other cycle a bubble (valid=0, selects 00) is written into EX instead.
module fwd_ctrl #(
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_wr,
  input  logic                id_load,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                ex_valid
);

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] rd;
    logic                wr;
    logic                load;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  slot_t      r_ex;
  slot_t      r_mem;
  slot_t      r_wb;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  logic       w_ex_src;
  logic       w_mem_src;
  logic       w_a_ex_hit;
  logic       w_a_mem_hit;
  logic       w_b_ex_hit;
  logic       w_b_mem_hit;
  logic       w_stall;
  logic       w_issue;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  slot_t      w_ex_next;
  logic       w_unused_wb;

  // A slot can feed a forward only if it will really write a non-zero register.
  // Requiring rd != 0 here also guarantees a zero source never matches.
  assign w_ex_src  = r_ex.valid  && r_ex.wr  && (r_ex.rd  != '0);
  assign w_mem_src = r_mem.valid && r_mem.wr && (r_mem.rd != '0);

  assign w_a_ex_hit  = id_use_rs1 && w_ex_src  && (r_ex.rd  == id_rs1);
  assign w_a_mem_hit = id_use_rs1 && w_mem_src && (r_mem.rd == id_rs1);
  assign w_b_ex_hit  = id_use_rs2 && w_ex_src  && (r_ex.rd  == id_rs2);
  assign w_b_mem_hit = id_use_rs2 && w_mem_src && (r_mem.rd == id_rs2);

  // A load in EX cannot forward next cycle (its data arrives only at WB), so a
  // dependent ID instruction waits one cycle and then picks it up from WB.
  // flush wins over stall: the killed instruction has no dependency to honour.
  assign w_stall = id_valid && !flush && w_ex_src && r_ex.load &&
                   (w_a_ex_hit || w_b_ex_hit);
  assign stall   = w_stall;

  assign w_issue = id_valid && !flush && !w_stall;

  // The producer now in EX will sit in MEM when this instruction reaches EX,
  // so it selects the MEM result; the one now in MEM will be in WB. The
  // younger producer is checked first so it wins when both match.
  always_comb begin
    w_sel_a = SEL_RF;
    if (w_a_ex_hit) begin
      w_sel_a = SEL_MEM;
    end else if (w_a_mem_hit) begin
      w_sel_a = SEL_WB;
    end
  end

  always_comb begin
    w_sel_b = SEL_RF;
    if (w_b_ex_hit) begin
      w_sel_b = SEL_MEM;
    end else if (w_b_mem_hit) begin
      w_sel_b = SEL_WB;
    end
  end

  always_comb begin
    w_ex_next = '0;
    if (w_issue) begin
      w_ex_next.valid = 1'b1;
      w_ex_next.rd    = id_rd;
      w_ex_next.wr    = id_wr;
      w_ex_next.load  = id_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= SEL_RF;
      r_fwd_b <= SEL_RF;
    end else begin
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_ex_next;
      r_fwd_a <= w_issue ? w_sel_a : SEL_RF;
      r_fwd_b <= w_issue ? w_sel_b : SEL_RF;
    end
  end

  // The WB slot is tracked for completeness of the pipeline picture, but the
  // register file writes before it reads, so WB never needs to forward.
  assign w_unused_wb = ^r_wb;

  assign fwd_a    = r_fwd_a;
  assign fwd_b    = r_fwd_b;
  assign ex_valid = r_ex.valid;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Testbench for fwd_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model that keeps
// the two most recently issued instructions.
module tb_fwd_ctrl;

  localparam int RB = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [RB-1:0] id_rs1;
  logic [RB-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RB-1:0] id_rd;
  logic          id_wr;
  logic          id_load;
  logic          flush;
  logic          stall;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          ex_valid;

  fwd_ctrl #(.REG_BITS(RB)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
    .flush(flush), .stall(stall),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_valid(ex_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is the instruction issued one cycle ago, hist[1] two cycles ago.
  typedef struct {
    bit          v;
    bit [RB-1:0] rd;
    bit          w;
    bit          ld;
  } ent_t;

  ent_t hist[2];
  bit   model_live = 0;
  bit [1:0] m_fwd_a, m_fwd_b;
  bit   m_ex_valid;

  function automatic bit produces(input ent_t e, input bit [RB-1:0] r);
    return e.v && e.w && (e.rd != 0) && (e.rd == r);
  endfunction

  function automatic bit [1:0] m_sel(input bit use_r, input bit [RB-1:0] r);
    if (!use_r) return 2'b00;
    if (produces(hist[0], r)) return 2'b01;
    if (produces(hist[1], r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    if (!id_valid || flush || !hist[0].ld) return 1'b0;
    return (id_use_rs1 && produces(hist[0], id_rs1)) ||
           (id_use_rs2 && produces(hist[0], id_rs2));
  endfunction

  always @(posedge clk) begin
    ent_t e;
    bit   issue;
    if (rst) begin
      hist[0] = '{default: 0};
      hist[1] = '{default: 0};
      m_fwd_a = 0; m_fwd_b = 0; m_ex_valid = 0;
      model_live = 1;
    end else if (model_live) begin
      issue = id_valid && !flush && !m_stall();
      m_fwd_a = issue ? m_sel(id_use_rs1, id_rs1) : 2'b00;
      m_fwd_b = issue ? m_sel(id_use_rs2, id_rs2) : 2'b00;
      m_ex_valid = issue;
      e = '{v: issue, rd: id_rd, w: id_wr, ld: id_load};
      hist[1] = hist[0];
      hist[0] = e;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_live) begin
      chk("cyc_stall", 32'(stall), 32'(m_stall()));
      chk("cyc_fwd_a", 32'(fwd_a), 32'(m_fwd_a));
      chk("cyc_fwd_b", 32'(fwd_b), 32'(m_fwd_b));
      chk("cyc_ex_valid", 32'(ex_valid), 32'(m_ex_valid));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int rs1, input int rs2, input bit u1,
                       input bit u2, input int rd, input bit wr, input bit ld,
                       input bit fl);
    id_valid = v; id_rs1 = RB'(rs1); id_rs2 = RB'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = RB'(rd);
    id_wr = wr; id_load = ld; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic alu(input int rs1, input int rs2, input int rd);
    drive(1, rs1, rs2, 1, 1, rd, 1, 0, 0);
    tick();
  endtask

  task automatic load(input int rs1, input int rd);
    drive(1, rs1, 0, 1, 0, rd, 1, 1, 0);
    tick();
  endtask

  task automatic drain();
    nop(); nop(); nop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hold;
    rst = 1'b1;
    drive(1, 3, 4, 1, 1, 3, 1, 1, 0);
    tick();
    drive(1, 7, 9, 1, 1, 2, 1, 0, 0);
    tick();
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    alu(1, 2, 10);
    chk("first_ex_valid", 32'(ex_valid), 32'd1);
    drain();

    // EX-EX forward
    alu(1, 2, 3);
    alu(3, 4, 11);
    chk("exex_fwd_a", 32'(fwd_a), 32'b01);
    chk("exex_fwd_b", 32'(fwd_b), 32'b00);
    drain();

    // youngest producer wins
    alu(1, 2, 5);
    alu(1, 2, 5);
    alu(5, 5, 12);
    chk("prio_fwd_a", 32'(fwd_a), 32'b01);
    chk("prio_fwd_b", 32'(fwd_b), 32'b01);
    drain();

    // MEM forward
    alu(1, 2, 6);
    nop();
    alu(1, 6, 13);
    chk("mem_fwd_a", 32'(fwd_a), 32'b00);
    chk("mem_fwd_b", 32'(fwd_b), 32'b10);
    drain();

    // load-use: one stall cycle, bubble, retry selects WB
    load(1, 7);
    drive(1, 7, 2, 1, 1, 14, 1, 0, 0);
    #1 chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall_once", 32'(stall), 32'd0);
    tick();
    chk("lu_retry_valid", 32'(ex_valid), 32'd1);
    chk("lu_retry_fwd_a", 32'(fwd_a), 32'b10);
    drain();

    // load, nop, use: no stall
    load(1, 7);
    nop();
    drive(1, 7, 2, 1, 1, 15, 1, 0, 0);
    #1 chk("lnu_stall", 32'(stall), 32'd0);
    tick();
    chk("lnu_fwd_a", 32'(fwd_a), 32'b10);
    drain();

    // register 0 never forwards
    alu(1, 2, 0);
    alu(0, 2, 16);
    chk("r0_fwd_a", 32'(fwd_a), 32'b00);
    drain();

    // unused source never stalls or forwards
    load(1, 8);
    drive(1, 1, 8, 1, 0, 17, 1, 0, 0);
    #1 chk("unused_stall", 32'(stall), 32'd0);
    tick();
    chk("unused_fwd_b", 32'(fwd_b), 32'b00);
    drain();

    // flush beats stall
    load(1, 9);
    drive(1, 9, 2, 1, 1, 18, 1, 0, 1);
    #1 chk("flush_stall", 32'(stall), 32'd0);
    tick();
    chk("flush_bubble", 32'(ex_valid), 32'd0);
    chk("flush_fwd_a", 32'(fwd_a), 32'b00);
    drain();

    // mid-run reset with three writers in flight
    alu(4, 4, 1);
    alu(4, 4, 2);
    alu(4, 4, 3);
    drive(1, 3, 2, 1, 1, 19, 1, 0, 0);
    rst = 1'b1;
    tick();
    chk("mrst_fwd_a", 32'(fwd_a), 32'b00);
    chk("mrst_fwd_b", 32'(fwd_b), 32'b00);
    chk("mrst_ex_valid", 32'(ex_valid), 32'd0);
    rst = 1'b0;
    alu(3, 2, 20);
    chk("mrst_no_fwd_a", 32'(fwd_a), 32'b00);
    chk("mrst_no_fwd_b", 32'(fwd_b), 32'b00);

    // randomized run; a stalled instruction is held as IF/ID would hold it
    hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!hold) begin
        drive($urandom_range(0, 99) < 85,
              $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7), $urandom_range(0, 4) != 0,
              $urandom_range(0, 9) < 3, 1'b0);
      end
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      #1;
      hold = stall && !rst;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
